ahblite_copy_master: RTL and testbench

// - AHB-Lite initiator that moves or fills memory on the M0 bus system.
// - Copy mode reads words from a source region and writes them to a destination region.
// - Fill mode writes a constant word to a destination region.
// - Drives single NONSEQ word transfers through the bus matrix into AHB-Lite responders (block RAM, peripherals).
// - Also used to preload or clear BRAM ahead of the core.

---
 rtl/ahb_lite_pkg.sv | 12 +
 rtl/ahblite_copy_master_if.sv | 22 ++
 rtl/ahblite_copy_master.sv | 132 +++++++++++++
 tb/tb_ahblite_copy_master.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg: AHB-Lite constants and copy-master FSM states
package ahb_lite_pkg;
    localparam logic [1:0] HTRANS_IDLE     = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
    localparam logic [2:0] HSIZE_WORD      = 3'b010;
    localparam logic [2:0] HBURST_SINGLE   = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;
    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_A, WR_D} state_t;
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction
endpackage

// File: rtl/ahblite_copy_master_if.sv
// ahblite_copy_master_if: AHB-Lite single-master bus bundle
interface ahblite_copy_master_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;
    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HREADY, HRDATA, HRESP
    );
    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HREADY, HRDATA, HRESP
    );
endinterface

// File: rtl/ahblite_copy_master.sv
// ahblite_copy_master: non-pipelined AHB-Lite copy/fill initiator
module ahblite_copy_master
    import ahb_lite_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 start,
    input  logic                 fill_mode,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [31:0]          fill_data,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    ahblite_copy_master_if.master bus
);
    state_t               state_q, state_d;
    logic [31:0]          src_q, src_d, dst_q, dst_d;
    logic [31:0]          data_q, data_d, fill_q, fill_d;
    logic [LEN_WIDTH-1:0] count_q, count_d;
    logic                 mode_q, mode_d;
    logic                 busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [31:0]          haddr_q, haddr_d, hwdata_q, hwdata_d;
    logic [1:0]           htrans_q, htrans_d;
    logic                 hwrite_q, hwrite_d;

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign bus.HADDR     = haddr_q;
    assign bus.HTRANS    = htrans_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HWDATA    = hwdata_q;
    assign bus.HSIZE     = HSIZE_WORD;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HPROT     = HPROT_DATA_PRIV;
    assign bus.HMASTLOCK = 1'b0;

    // Next state and job registers; bus outputs are derived from the next state so they are registered
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        data_d  = data_q;
        fill_d  = fill_q;
        count_d = count_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (len != '0) begin
                    src_d   = word_align(src_addr);
                    dst_d   = word_align(dst_addr);
                    count_d = len;
                    mode_d  = fill_mode;
                    fill_d  = fill_data;
                    state_d = fill_mode ? WR_A : RD_A;
                end else begin
                    done_d = 1'b1;
                end
            end
            RD_A: state_d = bus.HREADY ? RD_D : RD_A;
            RD_D: if (bus.HREADY) begin
                if (bus.HRESP) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    data_d  = bus.HRDATA;
                    src_d   = src_q + 32'd4;
                    state_d = WR_A;
                end
            end
            WR_A: state_d = bus.HREADY ? WR_D : WR_A;
            WR_D: if (bus.HREADY) begin
                if (bus.HRESP) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    dst_d   = dst_q + 32'd4;
                    count_d = count_q - 1'b1;
                    done_d  = count_q == LEN_WIDTH'(1);
                    state_d = (count_q == LEN_WIDTH'(1)) ? IDLE : (mode_q ? WR_A : RD_A);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d   = state_d != IDLE;
        htrans_d = (state_d == RD_A || state_d == WR_A) ? HTRANS_NONSEQ : HTRANS_IDLE;
        haddr_d  = (state_d == RD_A) ? src_d : (state_d == WR_A) ? dst_d : haddr_q;
        hwrite_d = (state_d == WR_A) ? 1'b1 : (state_d == RD_A) ? 1'b0 : hwrite_q;
        hwdata_d = (state_d == WR_D) ? (mode_q ? fill_q : data_q) : hwdata_q;
    end

    // State and output registers, cleared asynchronously so a reset drops the bus to IDLE at once
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            data_q   <= '0;
            fill_q   <= '0;
            count_q  <= '0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            haddr_q  <= '0;
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            data_q   <= data_d;
            fill_q   <= fill_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hwdata_q <= hwdata_d;
        end
    end
endmodule

// File: tb/tb_ahblite_copy_master.sv
// tb_ahblite_copy_master: directed bench with a BRAM-style responder that can add waits and errors
module tb_ahblite_copy_master;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        start = 1'b0, fill_mode = 1'b0;
    logic [31:0] src_addr = '0, dst_addr = '0, fill_data = '0;
    logic [15:0] len = '0;
    logic        busy, done, error;

    ahblite_copy_master_if bus();

    ahblite_copy_master #(.LEN_WIDTH(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .fill_mode(fill_mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .fill_data(fill_data), .len(len),
        .busy(busy), .done(done), .error(error), .bus(bus)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0, errors = 0;
    int waits = 0, err_at = 0, rd_cnt = 0;
    logic        dp = 1'b0, dp_write = 1'b0, dp_err = 1'b0;
    logic [31:0] dp_addr = '0;
    int          dp_cnt = 0, ap_cnt = 0;
    logic [31:0] mem [1024];
    logic        hready;
    int acc_cnt = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0, stab_err = 0;
    logic [31:0] wr_addr[$], wr_data[$];
    logic [1:0]  tlog[$];
    logic        hold_a = 1'b0, hold_d = 1'b0, pw = 1'b0;
    logic [31:0] pa = '0, pd = '0;
    logic [1:0]  pt = '0;

    assign hready     = dp ? (dp_err ? dp_cnt >= 1 : dp_cnt >= waits) : (!bus.HTRANS[1] || ap_cnt >= waits);
    assign bus.HREADY = hready;
    assign bus.HRESP  = dp && dp_err;
    assign bus.HRDATA = (dp && !dp_write) ? mem[dp_addr[11:2]] : 32'h0;

    // responder phase tracking
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp <= 1'b0; dp_cnt <= 0; ap_cnt <= 0; dp_write <= 1'b0; dp_addr <= '0; dp_err <= 1'b0;
        end else if (dp) begin
            if (hready) dp <= 1'b0;
            else dp_cnt <= dp_cnt + 1;
        end else if (bus.HTRANS[1]) begin
            if (hready) begin
                dp <= 1'b1; dp_cnt <= 0; ap_cnt <= 0;
                dp_write <= bus.HWRITE; dp_addr <= bus.HADDR;
                dp_err <= !bus.HWRITE && (rd_cnt + 1 == err_at);
                if (!bus.HWRITE) rd_cnt <= rd_cnt + 1;
            end else ap_cnt <= ap_cnt + 1;
        end
    end

    // bus monitor: write commit into memory, event counters, stability during waits
    always @(posedge HCLK) begin
        if (HRESETn) begin
            if (busy) tlog.push_back(bus.HTRANS);
            if (bus.HTRANS == 2'b10 && hready) acc_cnt++;
            if (dp && dp_write && hready && !dp_err) begin
                mem[dp_addr[11:2]] = bus.HWDATA;
                wr_cnt++;
                wr_addr.push_back(dp_addr);
                wr_data.push_back(bus.HWDATA);
            end
            if (done) done_cnt++;
            if (error) err_cnt++;
            if (hold_a && (bus.HADDR !== pa || bus.HTRANS !== pt || bus.HWRITE !== pw)) stab_err++;
            if (hold_d && bus.HWDATA !== pd) stab_err++;
            hold_a = bus.HTRANS[1] && !hready;
            pa = bus.HADDR; pt = bus.HTRANS; pw = bus.HWRITE;
            hold_d = dp && dp_write && !hready;
            pd = bus.HWDATA;
        end
    end

    task automatic run_job(input logic f, input logic [31:0] s, input logic [31:0] d,
                           input logic [31:0] fd, input logic [15:0] l, output int cyc, output int to);
        @(negedge HCLK);
        start = 1'b1; fill_mode = f; src_addr = s; dst_addr = d; fill_data = fd; len = l;
        @(negedge HCLK);
        start = 1'b0;
        cyc = 0;
        while (!done && !error && cyc < 2000) begin
            @(negedge HCLK);
            cyc++;
        end
        to = (done || error) ? 0 : 1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_status got %b%b%b want 000", busy, done, error); end
        checks++; if (bus.HTRANS !== 2'b00 || bus.HWRITE !== 1'b0) begin errors++; $display("FAIL reset_trans got %b/%b want 00/0", bus.HTRANS, bus.HWRITE); end
        checks++; if (bus.HADDR !== 32'h0 || bus.HWDATA !== 32'h0) begin errors++; $display("FAIL reset_addr_data got %h/%h want 0/0", bus.HADDR, bus.HWDATA); end
        checks++; if (bus.HSIZE !== 3'b010 || bus.HBURST !== 3'b000 || bus.HPROT !== 4'b0011 || bus.HMASTLOCK !== 1'b0) begin
            errors++; $display("FAIL const_ctrl got %b %b %b %b want 010 000 0011 0", bus.HSIZE, bus.HBURST, bus.HPROT, bus.HMASTLOCK); end
    endtask

    task automatic test_copy;
        int c, t, lb, wb, d0, bad;
        lb = tlog.size(); wb = wr_addr.size(); d0 = done_cnt; bad = 0;
        run_job(1'b0, 32'h0, 32'h100, 32'h0, 16'd4, c, t);
        checks++; if (t != 0) begin errors++; $display("FAIL copy_timeout got timeout want done"); end
        checks++; if (c != 16) begin errors++; $display("FAIL copy_cycles got %0d want 16", c); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL copy_busy_drop got %b want 0", busy); end
        @(negedge HCLK);
        checks++; if (tlog.size() - lb != 16) begin errors++; $display("FAIL copy_busy_len got %0d want 16", tlog.size() - lb); end
        for (int i = 0; i < 16 && lb + i < tlog.size(); i++) if (tlog[lb + i] !== ((i % 2 == 0) ? 2'b10 : 2'b00)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL copy_htrans_pattern got %0d bad want 0", bad); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem[32'h40 + i] !== 32'h11111111 * (i + 1)) begin errors++; $display("FAIL copy_data[%0d] got %h want %h", i, mem[32'h40 + i], 32'h11111111 * (i + 1)); end
        end
        checks++; if (wr_addr.size() - wb != 4) begin errors++; $display("FAIL copy_writes got %0d want 4", wr_addr.size() - wb); end
        else for (int i = 0; i < 4; i++) if (wr_addr[wb + i] !== 32'h100 + 4 * i) begin errors++; $display("FAIL copy_waddr[%0d] got %h want %h", i, wr_addr[wb + i], 32'h100 + 4 * i); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL copy_done_pulses got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_fill;
        int c, t, wb;
        wb = wr_addr.size();
        run_job(1'b1, 32'h0, 32'h203, 32'hDEADBEEF, 16'd3, c, t);
        checks++; if (t != 0 || c != 6) begin errors++; $display("FAIL fill_cycles got %0d (timeout %0d) want 6", c, t); end
        @(negedge HCLK);
        checks++; if (wr_addr.size() - wb != 3) begin errors++; $display("FAIL fill_writes got %0d want 3", wr_addr.size() - wb); end
        else for (int i = 0; i < 3; i++) begin
            checks++; if (wr_addr[wb + i] !== 32'h200 + 4 * i || wr_data[wb + i] !== 32'hDEADBEEF) begin
                errors++; $display("FAIL fill_write[%0d] got %h=%h want %h=deadbeef", i, wr_addr[wb + i], wr_data[wb + i], 32'h200 + 4 * i); end
        end
    endtask

    task automatic test_wait_states;
        int c, t, s0;
        s0 = stab_err; waits = 2;
        run_job(1'b0, 32'h10, 32'h180, 32'h0, 16'd2, c, t);
        checks++; if (t != 0 || c != 24) begin errors++; $display("FAIL wait_cycles got %0d (timeout %0d) want 24", c, t); end
        @(negedge HCLK);
        waits = 0;
        checks++; if (stab_err != s0) begin errors++; $display("FAIL wait_stability got %0d changes want 0", stab_err - s0); end
        checks++; if (mem[32'h60] !== 32'h55555555 || mem[32'h61] !== 32'h66666666) begin
            errors++; $display("FAIL wait_data got %h %h want 55555555 66666666", mem[32'h60], mem[32'h61]); end
    endtask

    task automatic test_error;
        int c, t, e0, d0, w0;
        e0 = err_cnt; d0 = done_cnt; w0 = wr_cnt;
        err_at = rd_cnt + 2;
        run_job(1'b0, 32'h20, 32'h300, 32'h0, 16'd3, c, t);
        checks++; if (t != 0 || error !== 1'b1) begin errors++; $display("FAIL err_pulse got error=%b (timeout %0d) want 1", error, t); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_busy got %b want 0", busy); end
        repeat (3) @(negedge HCLK);
        err_at = 0;
        checks++; if (err_cnt - e0 != 1 || done_cnt != d0) begin errors++; $display("FAIL err_counts got err=%0d done=%0d want 1 0", err_cnt - e0, done_cnt - d0); end
        checks++; if (wr_cnt - w0 != 1) begin errors++; $display("FAIL err_writes got %0d want 1", wr_cnt - w0); end
        checks++; if (mem[32'hC0] !== 32'h77777777 || mem[32'hC1] !== 32'h0) begin errors++; $display("FAIL err_mem got %h %h want 77777777 0", mem[32'hC0], mem[32'hC1]); end
        run_job(1'b1, 32'h0, 32'h340, 32'h12345678, 16'd1, c, t);
        @(negedge HCLK);
        checks++; if (t != 0 || mem[32'hD0] !== 32'h12345678) begin errors++; $display("FAIL err_restart got %h (timeout %0d) want 12345678", mem[32'hD0], t); end
    endtask

    task automatic test_len0_and_busy_start;
        int a0, d0, w0, n;
        a0 = acc_cnt;
        @(negedge HCLK);
        start = 1'b1; fill_mode = 1'b0; len = 16'd0; src_addr = 32'h0; dst_addr = 32'h3E0;
        @(negedge HCLK);
        start = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL len0_done got done=%b busy=%b want 1 0", done, busy); end
        @(negedge HCLK);
        checks++; if (done !== 1'b0 || acc_cnt != a0 || bus.HTRANS !== 2'b00) begin errors++; $display("FAIL len0_quiet got done=%b xfers=%0d want 0 0", done, acc_cnt - a0); end
        d0 = done_cnt; w0 = wr_cnt;
        start = 1'b1; fill_mode = 1'b1; len = 16'd2; dst_addr = 32'h380; fill_data = 32'hCAFEF00D;
        @(negedge HCLK);
        start = 1'b0;
        @(negedge HCLK);
        start = 1'b1; len = 16'd1; dst_addr = 32'h3C0; fill_data = 32'h0BAD0BAD;
        @(negedge HCLK);
        start = 1'b0;
        n = 0;
        while (n < 20) begin @(negedge HCLK); n++; end
        checks++; if (wr_cnt - w0 != 2 || done_cnt - d0 != 1) begin errors++; $display("FAIL busy_start got writes=%0d dones=%0d want 2 1", wr_cnt - w0, done_cnt - d0); end
        checks++; if (mem[32'hF0] !== 32'h0 || mem[32'hE1] !== 32'hCAFEF00D) begin errors++; $display("FAIL busy_start_mem got %h %h want 0 cafef00d", mem[32'hF0], mem[32'hE1]); end
    endtask

    task automatic test_reset_midjob;
        int w0, a0, n;
        w0 = wr_cnt;
        @(negedge HCLK);
        start = 1'b1; fill_mode = 1'b0; src_addr = 32'h0; dst_addr = 32'h240; len = 16'd4;
        @(negedge HCLK);
        start = 1'b0;
        n = 0;
        while (!(bus.HTRANS == 2'b10 && bus.HWRITE && wr_cnt == w0 + 1) && n < 100) begin @(negedge HCLK); n++; end
        checks++; if (n >= 100) begin errors++; $display("FAIL rst_reach_wr_a got timeout want WR_A of word 2"); end
        HRESETn = 1'b0;
        #1;
        checks++; if (bus.HTRANS !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rst_immediate got htrans=%b busy=%b want 00 0", bus.HTRANS, busy); end
        a0 = acc_cnt;
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (10) @(negedge HCLK);
        checks++; if (acc_cnt != a0 || busy !== 1'b0 || wr_cnt != w0 + 1) begin
            errors++; $display("FAIL rst_quiet got xfers=%0d busy=%b writes=%0d want 0 0 1", acc_cnt - a0, busy, wr_cnt - w0); end
        checks++; if (mem[32'h91] !== 32'h0) begin errors++; $display("FAIL rst_mem got %h want 0", mem[32'h91]); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        for (int i = 0; i < 4; i++) mem[i] = 32'h11111111 * (i + 1);
        mem[4] = 32'h55555555;
        mem[5] = 32'h66666666;
        mem[8] = 32'h77777777;
        mem[9] = 32'h88888888;
        test_reset;
        test_copy;
        test_fill;
        test_wait_states;
        test_error;
        test_len0_and_busy_start;
        test_reset_midjob;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
